// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice (two half adders + carry flop) reused
// once per bit, LSB first, between an operand handshake and a result handshake.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // ADD   | one bit per enabled cycle, LSB first
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic s1, c1, s, c2;
  logic carry_next;
  logic last_bit;

  half_adder u_ha1 (.x(a_sh[0]), .y(b_sh[0]), .s(s1), .c(c1));
  half_adder u_ha2 (.x(s1),      .y(carry),   .s(s),  .c(c2));

  assign carry_next = c1 | c2;
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh       <= a;
            b_sh       <= b;
            carry      <= 1'b0;
            cnt        <= '0;
            state      <= ADD;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ADD: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= {s, res[WIDTH-1:1]};
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          // The final bit is folded in directly so the result is ready on this edge.
          if (last_bit) begin
            sum_q       <= {s, res[WIDTH-1:1]};
            cout_q      <= carry_next;
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=4.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0, b = '0, sum;
  logic       cout, in_ready, out_valid, busy;

  logic       in_valid4 = 1'b0;
  logic       out_ready4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       cout4, in_ready4, out_valid4, busy4;

  int vec = 0;
  int miscmp = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  // Caller is at a negedge; the accept happens on the following posedge.
  task automatic accept8(input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vec++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      miscmp++;
      $display("FAIL reset8: got rdy=%b vld=%b busy=%b cout=%b sum=%0d want 1 0 0 0 0",
               in_ready, out_valid, busy, cout, sum);
    end
    vec++;
    if ({in_ready4, out_valid4, busy4, cout4, sum4} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      miscmp++;
      $display("FAIL reset4: got rdy=%b vld=%b busy=%b cout=%b sum=%0d want 1 0 0 0 0",
               in_ready4, out_valid4, busy4, cout4, sum4);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int n;
    out_ready = 1'b1;
    accept8(8'd3, 8'd5);
    vec++;
    if ({busy, in_ready} !== 2'b10) begin
      miscmp++;
      $display("FAIL basic_busy: got busy=%b rdy=%b want busy=1 rdy=0", busy, in_ready);
    end
    wait_valid8(n);
    vec++;
    if (n != 8) begin
      miscmp++;
      $display("FAIL basic_latency: got %0d want 8", n);
    end
    vec++;
    if ({cout, sum} !== 9'd8 || in_ready !== 1'b0) begin
      miscmp++;
      $display("FAIL basic_result: got cout=%b sum=%0d rdy=%b want 0 8 0", cout, sum, in_ready);
    end
    @(negedge clk);
    vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscmp++;
      $display("FAIL basic_ready_back: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_corners;
    logic [7:0] ta [3] = '{8'd255, 8'd255, 8'd0};
    logic [7:0] tb [3] = '{8'd1,   8'd255, 8'd0};
    logic [8:0] te [3] = '{9'h100, 9'h1FE,  9'h000};
    int n;
    for (int i = 0; i < 3; i++) begin
      accept8(ta[i], tb[i]);
      wait_valid8(n);
      vec++;
      if ({cout, sum} !== te[i] || n != 8) begin
        miscmp++;
        $display("FAIL corner%0d: got cout=%b sum=%0d lat=%0d want cout=%b sum=%0d lat=8",
                 i, cout, sum, n, te[i][8], te[i][7:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    int n;
    accept8(8'd170, 8'd85);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n++;
    end
    ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n++;
      vec++;
      if ({busy, out_valid, in_ready} !== 3'b100) begin
        miscmp++;
        $display("FAIL stall_frozen: got busy=%b vld=%b rdy=%b want 1 0 0", busy, out_valid, in_ready);
      end
    end
    ena = 1'b1;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vec++;
    if (n != 11) begin
      miscmp++;
      $display("FAIL stall_latency: got %0d want 11", n);
    end
    vec++;
    if ({cout, sum} !== 9'd255) begin
      miscmp++;
      $display("FAIL stall_result: got cout=%b sum=%0d want 0 255", cout, sum);
    end
    // With ena low the result must not be taken even though out_ready is high.
    ena = 1'b0;
    @(negedge clk);
    vec++;
    if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, 8'd255}) begin
      miscmp++;
      $display("FAIL stall_done_hold: got vld=%b rdy=%b sum=%0d want 1 0 255", out_valid, in_ready, sum);
    end
    ena = 1'b1;
    @(negedge clk);
    vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscmp++;
      $display("FAIL stall_take: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_hold;
    int n;
    out_ready = 1'b0;
    accept8(8'd200, 8'd100);
    wait_valid8(n);
    vec++;
    if (n != 8) begin
      miscmp++;
      $display("FAIL hold_latency: got %0d want 8", n);
    end
    repeat (5) begin
      in_valid = 1'b1;
      a = 8'd1;
      b = 8'd2;
      @(negedge clk);
      vec++;
      if ({out_valid, in_ready, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'd44}) begin
        miscmp++;
        $display("FAIL hold_stable: got vld=%b rdy=%b busy=%b cout=%b sum=%0d want 1 0 0 1 44",
                 out_valid, in_ready, busy, cout, sum);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    vec++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'd44}) begin
      miscmp++;
      $display("FAIL hold_take: got rdy=%b vld=%b busy=%b cout=%b sum=%0d want 1 0 0 1 44",
               in_ready, out_valid, busy, cout, sum);
    end
    @(negedge clk);
    vec++;
    if ({in_ready, busy} !== 2'b10) begin
      miscmp++;
      $display("FAIL hold_no_accept: got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    accept8(8'd10, 8'd20);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      miscmp++;
      $display("FAIL reset_mid: got rdy=%b vld=%b busy=%b cout=%b sum=%0d want 1 0 0 0 0",
               in_ready, out_valid, busy, cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    accept8(8'd100, 8'd27);
    wait_valid8(n);
    vec++;
    if ({cout, sum} !== 9'd127 || n != 8) begin
      miscmp++;
      $display("FAIL reset_resume: got cout=%b sum=%0d lat=%0d want 0 127 8", cout, sum, n);
    end
    @(negedge clk);
  endtask

  task automatic test_width4;
    logic [3:0] ta [3] = '{4'd9, 4'd15, 4'd7};
    logic [3:0] tb [3] = '{4'd9, 4'd15, 4'd8};
    logic [4:0] te [3] = '{5'h12, 5'h1E, 5'h0F};
    int n;
    for (int i = 0; i < 3; i++) begin
      a4 = ta[i];
      b4 = tb[i];
      in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      n = 0;
      while (out_valid4 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      vec++;
      if ({cout4, sum4} !== te[i] || n != 4) begin
        miscmp++;
        $display("FAIL w4_%0d: got cout=%b sum=%0d lat=%0d want cout=%b sum=%0d lat=4",
                 i, cout4, sum4, n, te[i][4], te[i][3:0]);
      end
      @(negedge clk);
      vec++;
      if (in_ready4 !== 1'b1) begin
        miscmp++;
        $display("FAIL w4_ready_%0d: got %b want 1", i, in_ready4);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] x, y;
    logic [8:0] expect_sum;
    int n;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      expect_sum = {1'b0, x} + {1'b0, y};
      accept8(x, y);
      wait_valid8(n);
      vec++;
      if ({cout, sum} !== expect_sum || n != 8) begin
        miscmp++;
        $display("FAIL random_%0d: a=%0d b=%0d got %0d lat=%0d want %0d lat=8",
                 i, x, y, {cout, sum}, n, expect_sum);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_stall;
    test_hold;
    test_reset_mid;
    test_width4;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
